// File: rtl/ipsxe_floating_point_multiplier_iter_v1_0.sv
// Iterative floating-point mantissa multiplier.
// Forms the sign, the raw biased-exponent sum and the exact, unrounded
// significand product of two packed operands, DIGIT_W multiplier bits per
// cycle, and classifies the operands into nan/inf/zero flags for the
// downstream align/round stage. Valid/ready handshake on both sides.
module ipsxe_floating_point_multiplier_iter_v1_0 #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int DIGIT_W   = 8
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic                                            i_aclken,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]                    i_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]                    i_b,
    input  logic                                            i_valid,
    output logic                                            o_ready,
    output logic [1+(EXP_WIDTH+1)+2*(MAN_WIDTH+1)-1:0]      o_result,
    output logic [2:0]                                      o_flags,
    output logic                                            o_valid,
    input  logic                                            i_ready
);

    localparam int OPW      = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int M        = MAN_WIDTH + 1;
    localparam int NUM_ITER = (M + DIGIT_W - 1) / DIGIT_W;
    localparam int SBW      = NUM_ITER * DIGIT_W;
    localparam int KW       = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [KW-1:0]          k_reg;
    logic [2*M-1:0]         sa_reg;     // multiplicand, pre-shifted to the current digit weight
    logic [SBW-1:0]         sb_reg;     // multiplier, consumed from the LSB end one digit per step
    logic [2*M-1:0]         acc_reg;
    logic                   sign_reg;
    logic [EXP_WIDTH:0]     exp_reg;
    logic [2:0]             flags_reg;

    // ------------------------------------------------------------------
    // Operand unpack and classification (same logic for A and B)
    // ------------------------------------------------------------------
    logic [OPW-1:0] ops     [2];
    logic [M-1:0]   op_sig  [2];
    logic [1:0]     op_nan;
    logic [1:0]     op_inf;
    logic [1:0]     op_zero;

    assign ops[0] = i_a;
    assign ops[1] = i_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cls
            logic exp_ones;
            logic exp_zero;
            logic man_zero;

            assign exp_ones    = &ops[gi][MAN_WIDTH +: EXP_WIDTH];
            assign exp_zero    = ~|ops[gi][MAN_WIDTH +: EXP_WIDTH];
            assign man_zero    = ~|ops[gi][MAN_WIDTH-1:0];
            // Implicit bit is set for every non-zero exponent; subnormals keep it clear.
            assign op_sig[gi]  = {~exp_zero, ops[gi][MAN_WIDTH-1:0]};
            assign op_nan[gi]  = exp_ones & ~man_zero;
            assign op_inf[gi]  = exp_ones & man_zero;
            assign op_zero[gi] = exp_zero & man_zero;
        end
    endgenerate

    logic                   in_nan;
    logic                   in_inf;
    logic                   in_zero;
    logic                   in_sign;
    logic [EXP_WIDTH:0]     in_exp;

    // inf * zero is an invalid operation and is reported as nan.
    assign in_nan  = |op_nan | (op_inf[0] & op_zero[1]) | (op_zero[0] & op_inf[1]);
    assign in_inf  = ~in_nan & |op_inf;
    assign in_zero = ~in_nan & ~in_inf & |op_zero;
    assign in_sign = i_a[OPW-1] ^ i_b[OPW-1];
    assign in_exp  = {1'b0, i_a[MAN_WIDTH +: EXP_WIDTH]} + {1'b0, i_b[MAN_WIDTH +: EXP_WIDTH]};

    // ------------------------------------------------------------------
    // Digit-serial datapath: one partial product per MUL cycle
    // ------------------------------------------------------------------
    logic [2*M-1:0] digit_ext;
    logic [2*M-1:0] partial;
    logic [2*M-1:0] acc_next;
    logic           last_step;

    assign digit_ext = (2*M)'(sb_reg[DIGIT_W-1:0]);
    assign partial   = sa_reg * digit_ext;
    assign acc_next  = acc_reg + partial;
    assign last_step = (k_reg == KW'(NUM_ITER - 1));

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic accept;
    logic xfer;

    // In DONE a new operand pair can only enter in the same cycle the result leaves.
    assign o_ready = ~i_rst & i_aclken &
                     ((state_reg == ST_IDLE) | ((state_reg == ST_DONE) & i_ready));
    assign accept  = i_valid & o_ready;
    assign xfer    = o_valid & i_ready & i_aclken;

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            sa_reg    <= '0;
            sb_reg    <= '0;
            acc_reg   <= '0;
            sign_reg  <= 1'b0;
            exp_reg   <= '0;
            flags_reg <= '0;
            o_result  <= '0;
            o_flags   <= '0;
            o_valid   <= 1'b0;
        end else if (i_aclken) begin
            case (state_reg)
                ST_MUL: begin
                    acc_reg <= acc_next;
                    sa_reg  <= sa_reg << DIGIT_W;
                    sb_reg  <= sb_reg >> DIGIT_W;
                    k_reg   <= k_reg + KW'(1);
                    if (last_step) begin
                        state_reg <= ST_DONE;
                        o_valid   <= 1'b1;
                        o_result  <= {sign_reg, exp_reg, acc_next};
                        o_flags   <= flags_reg;
                    end
                end
                ST_DONE: begin
                    if (xfer) begin
                        o_valid   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // Operand load; overrides the DONE->IDLE move for back-to-back operation.
            if (accept) begin
                sa_reg    <= (2*M)'(op_sig[0]);
                sb_reg    <= SBW'(op_sig[1]);
                sign_reg  <= in_sign;
                exp_reg   <= in_exp;
                flags_reg <= {in_nan, in_inf, in_zero};
                acc_reg   <= '0;
                k_reg     <= '0;
                state_reg <= ST_MUL;
            end
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_multiplier_iter_v1_0.sv
// Bench for the iterative mantissa multiplier: directed timing/handshake cases
// on the DIGIT_W=8 instance, plus per-instance scoreboards for DIGIT_W 8, 1, 24.
module tb_ipsxe_floating_point_multiplier_iter_v1_0;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_aclken;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;

    logic        rdy [3];
    logic        vld [3];
    logic [57:0] res [3];
    logic [2:0]  flg [3];

    int vec_cnt = 0;
    int err_cnt = 0;
    bit rnd_mode = 1'b0;

    logic [60:0] sb_q [3][$];

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {nan,inf,zero, sign, expA+expB, SA*SB}
    function automatic logic [60:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [23:0] sa;
        logic [23:0] sb;
        logic        nan_a, inf_a, z_a, nan_b, inf_b, z_b, nan, inf, zero;
        logic [47:0] p;
        logic [8:0]  e;
        ea    = a[30:23];
        eb    = b[30:23];
        sa    = {(ea != 8'd0), a[22:0]};
        sb    = {(eb != 8'd0), b[22:0]};
        nan_a = (ea == 8'hFF) && (a[22:0] != 23'd0);
        inf_a = (ea == 8'hFF) && (a[22:0] == 23'd0);
        z_a   = (ea == 8'h00) && (a[22:0] == 23'd0);
        nan_b = (eb == 8'hFF) && (b[22:0] != 23'd0);
        inf_b = (eb == 8'hFF) && (b[22:0] == 23'd0);
        z_b   = (eb == 8'h00) && (b[22:0] == 23'd0);
        nan   = nan_a | nan_b | (inf_a & z_b) | (z_a & inf_b);
        inf   = ~nan & (inf_a | inf_b);
        zero  = ~nan & ~inf & (z_a | z_b);
        p     = 48'(sa) * 48'(sb);
        e     = 9'(ea) + 9'(eb);
        return {nan, inf, zero, a[31] ^ b[31], e, p};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            ipsxe_floating_point_multiplier_iter_v1_0 #(
                .EXP_WIDTH (8),
                .MAN_WIDTH (23),
                .DIGIT_W   ((gi == 0) ? 8 : ((gi == 1) ? 1 : 24))
            ) u_dut (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_aclken (i_aclken),
                .i_a      (i_a),
                .i_b      (i_b),
                .i_valid  (i_valid),
                .o_ready  (rdy[gi]),
                .o_result (res[gi]),
                .o_flags  (flg[gi]),
                .o_valid  (vld[gi]),
                .i_ready  (i_ready)
            );

            // Scoreboard: inputs change at posedge+1, so the negedge sees what the next edge will sample.
            always @(negedge i_clk) begin
                if (i_rst) begin
                    sb_q[gi].delete();
                end else begin
                    if (vld[gi] && i_ready && i_aclken) begin
                        if (sb_q[gi].size() == 0) begin
                            check_eq($sformatf("sb%0d_unexpected", gi), 64'd1, 64'd0);
                        end else begin
                            logic [60:0] e;
                            e = sb_q[gi].pop_front();
                            check_eq($sformatf("sb%0d_result", gi), {flg[gi], res[gi]}, e);
                        end
                    end
                    if (i_valid && rdy[gi]) sb_q[gi].push_back(model(i_a, i_b));
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rnd_mode) begin
            i_ready  = ($urandom_range(0, 3) != 0);
            i_aclken = ($urandom_range(0, 7) != 0);
        end
    endtask

    // Present operands until the DIGIT_W=8 instance takes them; returns just after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok      = 1'b0;
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge i_clk);
            ok = rdy[0];
            tick();
        end
        i_valid = 1'b0;
        if (!ok) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    // Edge count from the accept edge (inclusive) to o_valid high.
    task automatic wait_valid(input int start, output int edges);
        edges = start;
        while (!vld[0] && edges < 300) begin
            tick();
            edges++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && n < 2000) begin
            tick();
            n++;
        end
        check_eq("drain", 64'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size()), 64'd0);
    endtask

    localparam logic [57:0] RES1 = {1'b0, 9'h0FF, 48'h600000000000};
    localparam logic [57:0] RES2 = {1'b1, 9'h07F, 48'h000000800000};

    initial begin
        int          e;
        logic [57:0] held;
        bit          seen;
        logic [31:0] ra, rb;
        logic [7:0]  ex;

        i_rst = 1'b1; i_aclken = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_a = '0; i_b = '0;
        tick(); tick();
        check_eq("reset_state", {vld[0], rdy[0], flg[0], res[0]}, 64'd0);
        i_rst = 1'b0;
        #1;
        check_eq("ready_after_reset", 64'(rdy[0]), 64'd1);

        // Case 1: 1.5 * 2.0
        send(32'h3FC00000, 32'h40000000);
        wait_valid(1, e);
        check_eq("c1_latency", 64'(e), 64'd4);
        check_eq("c1_result", {flg[0], res[0]}, {3'b000, RES1});
        tick();
        check_eq("c1_transfer", 64'(vld[0]), 64'd0);

        // Case 2: subnormal * -1.0
        send(32'h00000001, 32'hBF800000);
        wait_valid(1, e);
        check_eq("c2_result", {flg[0], res[0]}, {3'b000, RES2});

        // Case 3: flag classification
        send(32'h7F800000, 32'h00000000);
        wait_valid(1, e);
        check_eq("c3_inf_x_zero", 64'(flg[0]), 64'b100);
        send(32'h7F800000, 32'h40000000);
        wait_valid(1, e);
        check_eq("c3_inf", 64'(flg[0]), 64'b010);
        send(32'h00000000, 32'h3F800000);
        wait_valid(1, e);
        check_eq("c3_zero", 64'(flg[0]), 64'b001);
        wait_idle();

        // Case 4: downstream stall, then back-to-back accept
        i_ready = 1'b0;
        send(32'h00000001, 32'hBF800000);
        wait_valid(1, e);
        held = res[0];
        for (int n = 0; n < 10; n++) begin
            tick();
            check_eq("c4_hold", {vld[0], rdy[0], res[0]}, {1'b1, 1'b0, RES2});
        end
        check_eq("c4_held_value", 64'(held), 64'(RES2));
        i_ready = 1'b1;
        send(32'h3FC00000, 32'h40000000);
        wait_valid(1, e);
        check_eq("c4_b2b_latency", 64'(e), 64'd4);
        check_eq("c4_b2b_result", 64'(res[0]), 64'(RES1));
        wait_idle();

        // Case 5: clock enable low for 3 cycles mid-MUL
        send(32'h3FC00000, 32'h40000000);
        tick();
        i_aclken = 1'b0;
        tick(); tick(); tick();
        i_aclken = 1'b1;
        wait_valid(5, e);
        check_eq("c5_latency", 64'(e), 64'd7);
        check_eq("c5_result", 64'(res[0]), 64'(RES1));
        wait_idle();

        // Case 6: reset mid-MUL discards the operation
        send(32'h3FC00000, 32'h40000000);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            seen |= vld[0];
        end
        check_eq("c6_no_valid", {seen, rdy[0]}, {1'b0, 1'b1});
        send(32'h00000001, 32'hBF800000);
        wait_valid(1, e);
        check_eq("c6_next_latency", 64'(e), 64'd4);
        check_eq("c6_next_result", 64'(res[0]), 64'(RES2));
        wait_idle();

        // Random operands, all three digit widths, random stalls and enables
        rnd_mode = 1'b1;
        for (int n = 0; n < 30; n++) begin
            wait_idle();
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra[30:23] = 8'h00;
                1: rb[30:23] = 8'hFF;
                2: begin ra[30:0] = '0; end
                default: begin ex = 8'($urandom_range(1, 254)); ra[30:23] = ex; end
            endcase
            send(ra, rb);
        end
        rnd_mode = 1'b0;
        i_ready  = 1'b1;
        i_aclken = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
